// File: rtl/axi_stream_read_fifo_pkg.sv
// Shared defaults and helpers for the AXI-Stream receive FIFO.
// The writer and this reader both take their bus width from here.
package axi_stream_read_fifo_pkg;

  localparam int unsigned AXIS_BUS_WIDTH  = 16;
  localparam int unsigned AXIS_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Classify one cycle's traffic for the occupancy update.
  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/axi_stream_read_fifo_fifo.sv
// First-word-fall-through FIFO: storage, wrapping pointers and occupancy count.
// Full and empty come from the count, so the pointers can wrap freely.
module axi_stream_read_fifo_fifo
  import axi_stream_read_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = AXIS_BUS_WIDTH,
  parameter int unsigned DEPTH = AXIS_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  push_s;
  logic                  pop_s;
  logic                  empty_s;
  logic                  full_s;

  assign empty_s = (count_q == CNT_WIDTH'(0));
  assign full_s  = (count_q == CNT_WIDTH'(DEPTH));
  // A push into a full buffer or a pop from an empty one is dropped here too.
  assign push_s  = push_req & ~full_s;
  assign pop_s   = pop_req & ~empty_s;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case (fifo_op(push_s, pop_s))
      FIFO_PUSH: count_d = count_q + CNT_WIDTH'(1);
      FIFO_POP:  count_d = count_q - CNT_WIDTH'(1);
      default:   count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port; contents need no reset because valid gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign valid = ~empty_s;
  assign rdata = empty_s ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_s;

endmodule

// File: rtl/axi_stream_read_fifo.sv
// AXI-Stream slave receive stage: buffers beats and hands them to local logic FWFT.
// tready depends only on registered state and stays low until the first edge after reset.
module axi_stream_read_fifo
  import axi_stream_read_fifo_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = AXIS_BUS_WIDTH,
  parameter int unsigned DEPTH     = AXIS_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_aresetn,
  input  logic                     i_tvalid,
  output logic                     o_tready,
  input  logic [BUS_WIDTH-1:0]     i_tdata,
  input  logic                     i_read_enable,
  output logic                     o_data_valid,
  output logic [BUS_WIDTH-1:0]     o_data,
  output logic [$clog2(DEPTH):0]   o_fill_count,
  output logic                     o_full
);

  logic ready_en_q, ready_en_d;
  logic push_s;
  logic pop_s;
  logic full_s;
  logic valid_s;

  assign ready_en_d = 1'b1;

  // Reset-release gate for tready.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
    end
  end

  assign o_tready = ready_en_q & ~full_s;
  assign push_s   = i_tvalid & o_tready;
  assign pop_s    = i_read_enable & valid_s;

  axi_stream_read_fifo_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_aresetn),
    .push_req (push_s),
    .pop_req  (pop_s),
    .wdata    (i_tdata),
    .rdata    (o_data),
    .valid    (valid_s),
    .count    (o_fill_count),
    .full     (full_s)
  );

  assign o_data_valid = valid_s;
  assign o_full       = full_s;

endmodule

// File: tb/tb_axi_stream_read_fifo.sv
// Bench for axi_stream_read_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axi_stream_read_fifo;

  localparam int DEPTH = 4;
  localparam int W     = 16;

  logic          i_clk = 1'b0;
  logic          i_aresetn;
  logic          i_tvalid;
  logic          o_tready;
  logic [W-1:0]  i_tdata;
  logic          i_read_enable;
  logic          o_data_valid;
  logic [W-1:0]  o_data;
  logic [2:0]    o_fill_count;
  logic          o_full;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq[$];
  bit           m_ready_en = 1'b0;

  axi_stream_read_fifo #(.BUS_WIDTH(W), .DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_aresetn     (i_aresetn),
    .i_tvalid      (i_tvalid),
    .o_tready      (o_tready),
    .i_tdata       (i_tdata),
    .i_read_enable (i_read_enable),
    .o_data_valid  (o_data_valid),
    .o_data        (o_data),
    .o_fill_count  (o_fill_count),
    .o_full        (o_full)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted beats, ready once a clean edge has passed.
  always @(posedge i_clk or negedge i_aresetn) begin
    bit do_push;
    bit do_pop;
    if (!i_aresetn) begin
      mq.delete();
      m_ready_en <= 1'b0;
    end else begin
      do_push = i_tvalid && m_ready_en && (mq.size() < DEPTH);
      do_pop  = i_read_enable && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(i_tdata);
      m_ready_en <= 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("m_tready", {31'd0, o_tready}, {31'd0, m_ready_en && (mq.size() < DEPTH)});
      chk("m_valid",  {31'd0, o_data_valid}, {31'd0, mq.size() != 0});
      chk("m_data",   {16'd0, o_data}, (mq.size() != 0) ? {16'd0, mq[0]} : 32'd0);
      chk("m_count",  {29'd0, o_fill_count}, 32'(mq.size()));
      chk("m_full",   {31'd0, o_full}, {31'd0, mq.size() == DEPTH});
    end
  end

  initial begin
    int sent;
    int got;
    bit acc;
    i_aresetn     = 1'b1;
    i_tvalid      = 1'b0;
    i_tdata       = 16'h0000;
    i_read_enable = 1'b0;
    #1 i_aresetn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(negedge i_clk);

    // 1: reset release
    i_aresetn = 1'b1;
    #1 chk("t1_tready_before_edge", {31'd0, o_tready}, 32'd0);
    @(negedge i_clk);
    chk("t1_tready_after_edge", {31'd0, o_tready}, 32'd1);
    chk("t1_valid", {31'd0, o_data_valid}, 32'd0);
    chk("t1_count", {29'd0, o_fill_count}, 32'd0);

    // 2: single beat then pop
    i_tvalid = 1'b1; i_tdata = 16'hA5A5;
    @(negedge i_clk);
    i_tvalid = 1'b0;
    chk("t2_valid", {31'd0, o_data_valid}, 32'd1);
    chk("t2_data", {16'd0, o_data}, 32'h0000A5A5);
    chk("t2_count", {29'd0, o_fill_count}, 32'd1);
    i_read_enable = 1'b1;
    @(negedge i_clk);
    i_read_enable = 1'b0;
    chk("t2_count_after_pop", {29'd0, o_fill_count}, 32'd0);
    chk("t2_data_after_pop", {16'd0, o_data}, 32'd0);

    // 3: fill, hold a fifth beat, drain
    for (int k = 1; k <= 4; k++) begin
      i_tvalid = 1'b1; i_tdata = 16'(k);
      @(negedge i_clk);
    end
    i_tvalid = 1'b0;
    chk("t3_full", {31'd0, o_full}, 32'd1);
    chk("t3_tready_full", {31'd0, o_tready}, 32'd0);
    chk("t3_count_full", {29'd0, o_fill_count}, 32'd4);
    i_tvalid = 1'b1; i_tdata = 16'd5; i_read_enable = 1'b1;
    @(negedge i_clk);
    i_read_enable = 1'b0;
    chk("t3_head_after_pop", {16'd0, o_data}, 32'd2);
    chk("t3_count_no_same_cycle_push", {29'd0, o_fill_count}, 32'd3);
    chk("t3_tready_reopened", {31'd0, o_tready}, 32'd1);
    @(negedge i_clk);
    i_tvalid = 1'b0;
    chk("t3_count_held_beat_in", {29'd0, o_fill_count}, 32'd4);
    for (int e = 2; e <= 5; e++) begin
      chk("t3_drain_data", {16'd0, o_data}, 32'(e));
      i_read_enable = 1'b1;
      @(negedge i_clk);
    end
    i_read_enable = 1'b0;
    chk("t3_drained", {29'd0, o_fill_count}, 32'd0);

    // 4: streaming push+pop through pointer wrap
    for (int k = 0; k < 10; k++) begin
      i_tvalid = 1'b1; i_tdata = 16'(k); i_read_enable = 1'b1;
      @(negedge i_clk);
      chk("t4_count", {29'd0, o_fill_count}, 32'd1);
      chk("t4_data", {16'd0, o_data}, 32'(k));
    end
    i_tvalid = 1'b0;
    @(negedge i_clk);
    i_read_enable = 1'b0;
    chk("t4_empty", {29'd0, o_fill_count}, 32'd0);

    // 5: read enable while empty
    i_read_enable = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("t5_count", {29'd0, o_fill_count}, 32'd0);
      chk("t5_data", {16'd0, o_data}, 32'd0);
    end
    i_read_enable = 1'b0;

    // 6: asynchronous reset with three beats buffered
    for (int k = 0; k < 3; k++) begin
      i_tvalid = 1'b1; i_tdata = 16'h1111 * 16'(k + 1);
      @(negedge i_clk);
    end
    chk("t6_count_pre", {29'd0, o_fill_count}, 32'd3);
    i_tdata = 16'h7777;
    @(posedge i_clk);
    #2 i_aresetn = 1'b0;
    #1;
    chk("t6_tready", {31'd0, o_tready}, 32'd0);
    chk("t6_valid", {31'd0, o_data_valid}, 32'd0);
    chk("t6_data", {16'd0, o_data}, 32'd0);
    chk("t6_count", {29'd0, o_fill_count}, 32'd0);
    chk("t6_full", {31'd0, o_full}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_aresetn = 1'b1;
    @(negedge i_clk);
    i_tvalid = 1'b0;
    chk("t6_empty_after_release", {29'd0, o_fill_count}, 32'd0);

    // Integration: writer sends 8 beats honouring tready, consumer pops at random
    sent = 0; got = 0;
    i_tvalid = 1'b1; i_tdata = 16'h0100;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      acc = i_tvalid && o_tready;
      if (i_read_enable && o_data_valid) begin
        chk("int_order", {16'd0, o_data}, 32'h100 + 32'(got));
        got++;
      end
      @(negedge i_clk);
      if (acc) sent++;
      i_tvalid      = (sent < 8);
      i_tdata       = 16'h0100 + 16'(sent);
      i_read_enable = 1'($urandom_range(0, 1));
    end
    chk("int_all_received", 32'(got), 32'd8);
    i_tvalid = 1'b0; i_read_enable = 1'b1;
    repeat (6) @(negedge i_clk);

    // Randomized traffic with varying producer and consumer pressure
    for (int c = 0; c < 3000; c++) begin
      i_tvalid      = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 80 : 30));
      i_tdata       = 16'($urandom);
      i_read_enable = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 30 : 80));
      @(negedge i_clk);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
